// File: rtl/opb_reg_pkg.sv
// Shared types and helpers for the PPC-to-fabric OPB register: FSM states,
// register offsets and the byte-lane write merge.
package opb_reg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [7:0] OFF_DATA   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;

    // be[3] is OPB BE[0] and guards the most significant byte.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// Address-window decode, single-ack transfer FSM and capture of the bus
// qualifiers for the OPB slave register.
//
// state | meaning
// IDLE  | waiting for a select that falls inside the address window
// ACK   | xferAck high; read data on the bus, write committed at cycle end
// HOLD  | waiting for select to drop so one select yields exactly one ack
module opb_slave_ack_fsm
    import opb_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h0100E200,
    parameter logic [31:0] C_HIGHADDR = 32'h0100E2FF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_select,
    input  logic        i_rnw,
    input  logic [31:0] i_abus,
    input  logic [3:0]  i_be,
    input  logic [31:0] i_dbus,
    output logic        o_xfer_ack,
    output logic        o_capture,
    output logic        o_commit,
    output logic        o_live_is_data,
    output logic        o_live_is_status,
    output logic        o_cap_is_data,
    output logic [3:0]  o_cap_be,
    output logic [31:0] o_cap_dbus
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_rnw;
    logic        r_is_data;
    logic [3:0]  r_be;
    logic [31:0] r_dbus;
    logic        w_hit;
    logic [31:0] w_offset;

    assign w_hit    = i_select && (i_abus >= C_BASEADDR) && (i_abus <= C_HIGHADDR);
    assign w_offset = i_abus - C_BASEADDR;

    assign o_live_is_data   = (w_offset == {24'h000000, OFF_DATA});
    assign o_live_is_status = (w_offset == {24'h000000, OFF_STATUS});
    assign o_capture        = (r_state == IDLE) && w_hit;
    assign o_xfer_ack       = (r_state == ACK);
    assign o_commit         = (r_state == ACK) && !r_rnw;
    assign o_cap_is_data    = r_is_data;
    assign o_cap_be         = r_be;
    assign o_cap_dbus       = r_dbus;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_hit) w_state_nxt = ACK;
            ACK:     w_state_nxt = HOLD;
            HOLD:    if (!i_select) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_rnw     <= 1'b1;
            r_is_data <= 1'b0;
            r_be      <= '0;
            r_dbus    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (o_capture) begin
                r_rnw     <= i_rnw;
                r_is_data <= o_live_is_data;
                r_be      <= i_be;
                r_dbus    <= i_dbus;
            end
        end
    end

endmodule

// File: rtl/opb_register_ppc2fabric.sv
// OPB slave register carrying a 32-bit control word from the PowerPC to fabric
// logic, plus a read-only status word exposing a wrapping DATA-write counter.
module opb_register_ppc2fabric
    import opb_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR    = 32'h0100E200,
    parameter logic [31:0] C_HIGHADDR    = 32'h0100E2FF,
    parameter int          C_OPB_AWIDTH  = 32,
    parameter int          C_OPB_DWIDTH  = 32,
    parameter              C_FAMILY      = "virtex6",
    parameter logic [31:0] C_RESET_VALUE = 32'h00000000
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst,
    output logic [0:31] Sl_DBus,
    output logic        Sl_errAck,
    output logic        Sl_retry,
    output logic        Sl_toutSup,
    output logic        Sl_xferAck,
    input  logic [0:31] OPB_ABus,
    input  logic [0:3]  OPB_BE,
    input  logic [0:31] OPB_DBus,
    input  logic        OPB_RNW,
    input  logic        OPB_select,
    input  logic        OPB_seqAddr,
    output logic [31:0] user_data_out,
    output logic        user_data_valid
);

    logic [31:0] r_data;
    logic [15:0] r_wr_count;
    logic        r_valid;
    logic [31:0] r_sl_dbus;

    // Positional assignment puts OPB bit 0 on user bit 31.
    logic [31:0] w_abus;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic        w_xfer_ack;
    logic        w_capture;
    logic        w_commit;
    logic        w_live_is_data;
    logic        w_live_is_status;
    logic        w_cap_is_data;
    logic [3:0]  w_cap_be;
    logic [31:0] w_cap_dbus;
    logic        w_unused;

    assign w_abus  = OPB_ABus;
    assign w_wdata = OPB_DBus;
    assign w_be    = OPB_BE;

    assign w_unused = &{OPB_seqAddr, (C_FAMILY == "virtex6"),
                        (C_OPB_AWIDTH == 32), (C_OPB_DWIDTH == 32)};

    opb_slave_ack_fsm #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR)
    ) u_ack_fsm (
        .i_clk            (OPB_Clk),
        .i_rst            (OPB_Rst),
        .i_select         (OPB_select),
        .i_rnw            (OPB_RNW),
        .i_abus           (w_abus),
        .i_be             (w_be),
        .i_dbus           (w_wdata),
        .o_xfer_ack       (w_xfer_ack),
        .o_capture        (w_capture),
        .o_commit         (w_commit),
        .o_live_is_data   (w_live_is_data),
        .o_live_is_status (w_live_is_status),
        .o_cap_is_data    (w_cap_is_data),
        .o_cap_be         (w_cap_be),
        .o_cap_dbus       (w_cap_dbus)
    );

    // Read data is loaded on the capture edge so it is valid exactly in ACK.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_data     <= C_RESET_VALUE;
            r_wr_count <= '0;
            r_valid    <= 1'b0;
            r_sl_dbus  <= '0;
        end else begin
            r_valid   <= 1'b0;
            r_sl_dbus <= '0;
            if (w_commit && w_cap_is_data) begin
                r_data     <= merge_bytes(r_data, w_cap_dbus, w_cap_be);
                r_wr_count <= r_wr_count + 16'd1;
                r_valid    <= 1'b1;
            end
            if (w_capture && OPB_RNW) begin
                if (w_live_is_data)        r_sl_dbus <= r_data;
                else if (w_live_is_status) r_sl_dbus <= {16'h0000, r_wr_count};
            end
        end
    end

    assign Sl_DBus         = r_sl_dbus;
    assign Sl_xferAck      = w_xfer_ack;
    assign Sl_errAck       = 1'b0;
    assign Sl_retry        = 1'b0;
    assign Sl_toutSup      = 1'b0;
    assign user_data_out   = r_data;
    assign user_data_valid = r_valid;

endmodule

// File: tb/tb_opb_register_ppc2fabric.sv
// Directed, table-driven bench for the PPC-to-fabric OPB register, with
// hand-written sequences for held select, counter wrap and reset during ACK.
module tb_opb_register_ppc2fabric;

    localparam logic [31:0] BASE  = 32'h0100E200;
    localparam logic [31:0] HIGH  = 32'h0100E2FF;
    localparam logic [31:0] RSTV  = 32'hA5A50001;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:31] sl_dbus;
    logic        sl_erracK_unused;
    logic        sl_errack;
    logic        sl_retry;
    logic        sl_toutsup;
    logic        sl_xferack;
    logic [0:31] opb_abus;
    logic [0:3]  opb_be;
    logic [0:31] opb_dbus;
    logic        opb_rnw;
    logic        opb_select;
    logic        opb_seqaddr;
    logic [31:0] user_data_out;
    logic        user_data_valid;

    int total = 0;
    int bad   = 0;
    int dbl_valid = 0;
    logic valid_prev = 1'b0;

    always #5 clk = ~clk;

    opb_register_ppc2fabric #(
        .C_RESET_VALUE (RSTV)
    ) dut (
        .OPB_Clk         (clk),
        .OPB_Rst         (rst),
        .Sl_DBus         (sl_dbus),
        .Sl_errAck       (sl_errack),
        .Sl_retry        (sl_retry),
        .Sl_toutSup      (sl_toutsup),
        .Sl_xferAck      (sl_xferack),
        .OPB_ABus        (opb_abus),
        .OPB_BE          (opb_be),
        .OPB_DBus        (opb_dbus),
        .OPB_RNW         (opb_rnw),
        .OPB_select      (opb_select),
        .OPB_seqAddr     (opb_seqaddr),
        .user_data_out   (user_data_out),
        .user_data_valid (user_data_valid)
    );

    always @(negedge clk) begin
        if (user_data_valid && valid_prev) dbl_valid++;
        valid_prev = user_data_valid;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    // One transfer at minimum spacing; returns ack latency (-1 = none) and
    // values sampled in the ack cycle and the following cycle.
    task automatic xfer(input logic rnw, input logic [31:0] addr, input logic [0:3] be,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic [31:0] usr_at_ack, output logic [31:0] usr_after,
                        output logic vld_after, output logic [31:0] dbus_after);
        @(negedge clk);
        opb_select = 1'b1;
        opb_rnw    = rnw;
        opb_abus   = addr;
        opb_be     = be;
        opb_dbus   = wd;
        lat        = -1;
        rd         = '0;
        usr_at_ack = user_data_out;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (sl_xferack) begin
                lat        = i;
                rd         = sl_dbus;
                usr_at_ack = user_data_out;
                break;
            end
        end
        opb_select = 1'b0;
        opb_rnw    = 1'b0;
        opb_abus   = '0;
        opb_be     = '0;
        opb_dbus   = '0;
        @(negedge clk);
        usr_after  = user_data_out;
        vld_after  = user_data_valid;
        dbus_after = sl_dbus;
    endtask

    typedef struct {
        logic        rnw;
        logic [31:0] addr;
        logic [0:3]  be;
        logic [31:0] wd;
        int          lat;
        logic [31:0] rd;
        logic [31:0] usr;
        logic        vld;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rnw, input logic [31:0] addr, input logic [0:3] be,
                       input logic [31:0] wd, input int lat, input logic [31:0] rd,
                       input logic [31:0] usr, input logic vld);
        vec_t v;
        v.rnw = rnw; v.addr = addr; v.be = be; v.wd = wd;
        v.lat = lat; v.rd = rd; v.usr = usr; v.vld = vld;
        vq.push_back(v);
    endtask

    initial begin
        int          lat;
        int          acks;
        int          stray;
        int          vlds;
        logic [31:0] rd;
        logic [31:0] ua;
        logic [31:0] uf;
        logic        vf;
        logic [31:0] df;
        logic [31:0] prev_usr;

        rst = 1'b1; opb_select = 1'b0; opb_rnw = 1'b0; opb_abus = '0;
        opb_be = '0; opb_dbus = '0; opb_seqaddr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(sl_xferack), 32'd0);
        chk("rst_dbus", sl_dbus, 32'd0);
        chk("rst_user", user_data_out, RSTV);
        chk("rst_valid", 32'(user_data_valid), 32'd0);
        rst = 1'b0;

        add(1'b1, BASE,        4'b1111, 32'h0,        1, RSTV,          RSTV,          1'b0);
        add(1'b0, BASE,        4'b1111, 32'hDEADBEEF, 1, 32'h0,         32'hDEADBEEF,  1'b1);
        add(1'b1, BASE + 4,    4'b1111, 32'h0,        1, 32'h00000001,  32'hDEADBEEF,  1'b0);
        add(1'b0, BASE,        4'b0101, 32'h11223344, 1, 32'h0,         32'hDE22BE44,  1'b1);
        add(1'b1, BASE,        4'b1111, 32'h0,        1, 32'hDE22BE44,  32'hDE22BE44,  1'b0);
        add(1'b0, BASE,        4'b0000, 32'hFFFFFFFF, 1, 32'h0,         32'hDE22BE44,  1'b1);
        add(1'b1, BASE + 4,    4'b1111, 32'h0,        1, 32'h00000003,  32'hDE22BE44,  1'b0);
        add(1'b0, BASE + 'h10, 4'b1111, 32'hFFFFFFFF, 1, 32'h0,         32'hDE22BE44,  1'b0);
        add(1'b1, BASE + 'h10, 4'b1111, 32'h0,        1, 32'h0,         32'hDE22BE44,  1'b0);
        add(1'b0, BASE + 4,    4'b1111, 32'h12345678, 1, 32'h0,         32'hDE22BE44,  1'b0);
        add(1'b1, BASE + 4,    4'b1111, 32'h0,        1, 32'h00000003,  32'hDE22BE44,  1'b0);
        add(1'b1, HIGH + 4,    4'b1111, 32'h0,       -1, 32'h0,         32'hDE22BE44,  1'b0);
        add(1'b0, HIGH + 4,    4'b1111, 32'h0,       -1, 32'h0,         32'hDE22BE44,  1'b0);
        add(1'b1, BASE - 4,    4'b1111, 32'h0,       -1, 32'h0,         32'hDE22BE44,  1'b0);
        add(1'b1, HIGH,        4'b1111, 32'h0,        1, 32'h0,         32'hDE22BE44,  1'b0);
        add(1'b0, BASE,        4'b1000, 32'hAABBCCDD, 1, 32'h0,         32'hAA22BE44,  1'b1);
        add(1'b1, BASE,        4'b1111, 32'h0,        1, 32'hAA22BE44,  32'hAA22BE44,  1'b0);
        add(1'b1, BASE + 4,    4'b1111, 32'h0,        1, 32'h00000004,  32'hAA22BE44,  1'b0);

        prev_usr = RSTV;
        foreach (vq[i]) begin
            xfer(vq[i].rnw, vq[i].addr, vq[i].be, vq[i].wd, lat, rd, ua, uf, vf, df);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vq[i].lat));
            chk($sformatf("v%0d_rdata", i), rd, vq[i].rd);
            chk($sformatf("v%0d_user_at_ack", i), ua, prev_usr);
            chk($sformatf("v%0d_user", i), uf, vq[i].usr);
            chk($sformatf("v%0d_valid", i), 32'(vf), 32'(vq[i].vld));
            chk($sformatf("v%0d_dbus_idle", i), df, 32'h0);
            prev_usr = vq[i].usr;
        end

        // Select held for six cycles on one read.
        @(negedge clk);
        opb_select = 1'b1; opb_rnw = 1'b1; opb_abus = BASE; opb_be = 4'b1111;
        acks = 0; stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (sl_xferack) begin
                acks++;
                chk("held_rdata", sl_dbus, 32'hAA22BE44);
            end else if (sl_dbus != 32'h0) begin
                stray++;
            end
        end
        opb_select = 1'b0; opb_rnw = 1'b0; opb_abus = '0;
        @(negedge clk);
        chk("held_ack_count", 32'(acks), 32'd1);
        chk("held_dbus_stray", 32'(stray), 32'd0);

        // Counter wrap: preload to the top of the range and write through it.
        @(negedge clk);
        force dut.r_wr_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_wr_count;
        xfer(1'b0, BASE, 4'b1111, 32'h01020304, lat, rd, ua, uf, vf, df);
        chk("wrap_user", uf, 32'h01020304);
        xfer(1'b1, BASE + 4, 4'b1111, 32'h0, lat, rd, ua, uf, vf, df);
        chk("wrap_status0", rd, 32'h00000000);
        xfer(1'b0, BASE, 4'b1111, 32'h0A0B0C0D, lat, rd, ua, uf, vf, df);
        xfer(1'b1, BASE + 4, 4'b1111, 32'h0, lat, rd, ua, uf, vf, df);
        chk("wrap_status1", rd, 32'h00000001);

        // Reset asserted during the ACK cycle of a write.
        @(negedge clk);
        opb_select = 1'b1; opb_rnw = 1'b0; opb_abus = BASE;
        opb_be = 4'b1111; opb_dbus = 32'h55555555;
        @(negedge clk);
        chk("rstack_ack_seen", 32'(sl_xferack), 32'd1);
        rst = 1'b1;
        opb_select = 1'b0; opb_dbus = '0; opb_abus = '0;
        @(negedge clk);
        chk("rstack_user", user_data_out, RSTV);
        rst = 1'b0;
        acks = 0; vlds = 0;
        repeat (4) begin
            @(negedge clk);
            if (sl_xferack) acks++;
            if (user_data_valid) vlds++;
        end
        chk("rstack_no_ack", 32'(acks), 32'd0);
        chk("rstack_no_valid", 32'(vlds), 32'd0);
        xfer(1'b1, BASE + 4, 4'b1111, 32'h0, lat, rd, ua, uf, vf, df);
        chk("rstack_status", rd, 32'h00000000);
        xfer(1'b1, BASE, 4'b1111, 32'h0, lat, rd, ua, uf, vf, df);
        chk("rstack_data", rd, RSTV);

        chk("valid_width", 32'(dbl_valid), 32'd0);
        chk("const_outputs", {29'h0, sl_errack, sl_retry, sl_toutsup}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
